// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage
// Description : Pipeline stage between execute and writeback. Accepts one
//               executed instruction over the prev_done/stall_prev handshake.
//               Loads and stores issue a single request on the data-memory
//               valid/ready port, wait for the response, and format load
//               data by funct3. Non-memory instructions pass through with one
//               cycle of latency. Results leave over done_next/next_stall.
// Ports       : clk, rst_n (async, active-low)
//               upstream   : prev_done, stall_prev, *_in instruction fields
//               downstream : done_next, next_stall, *_out result fields,
//                            memory_exception_out
//               memory     : mem_req_valid/ready, mem_addr, mem_write,
//                            mem_wdata, mem_wstrb, mem_resp_valid, mem_rdata
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage #(
  parameter int ADDR_WIDTH              = 32,
  parameter int DATA_WIDTH              = 32,
  parameter int REGISTER_INDEXING_WIDTH = 5
) (
  input  logic                               clk,
  input  logic                               rst_n,
  // upstream handshake
  input  logic                               prev_done,
  output logic                               stall_prev,
  // downstream handshake
  output logic                               done_next,
  input  logic                               next_stall,
  // instruction fields
  input  logic [ADDR_WIDTH-1:0]              program_count_in,
  output logic [ADDR_WIDTH-1:0]              program_count_out,
  input  logic                               load_in,
  input  logic                               store_in,
  input  logic [2:0]                         funct_3_in,
  input  logic                               funct_3_valid_in,
  input  logic [DATA_WIDTH-1:0]              result_data_in,
  input  logic                               result_data_valid_in,
  input  logic [DATA_WIDTH-1:0]              memory_store_data_in,
  input  logic                               memory_store_data_valid_in,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] write_register_in,
  input  logic                               write_register_valid_in,
  output logic [REGISTER_INDEXING_WIDTH-1:0] write_register_out,
  output logic                               write_register_valid_out,
  output logic [DATA_WIDTH-1:0]              result_data_out,
  output logic                               result_data_valid_out,
  output logic                               memory_exception_out,
  // data-memory port
  output logic                               mem_req_valid,
  input  logic                               mem_req_ready,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic                               mem_write,
  output logic [DATA_WIDTH-1:0]              mem_wdata,
  output logic [DATA_WIDTH/8-1:0]            mem_wstrb,
  input  logic                               mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]              mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]                         state_q, state_d;
  logic [ADDR_WIDTH-1:0]              pc_q;
  logic                               store_q;
  logic [2:0]                         f3_q;
  logic [ADDR_WIDTH-1:0]              ea_q;
  logic [DATA_WIDTH-1:0]              sdata_q;
  logic [REGISTER_INDEXING_WIDTH-1:0] rd_q;
  logic                               rd_valid_q;
  logic [DATA_WIDTH-1:0]              result_q;
  logic                               result_valid_q;
  logic                               exc_q;

  logic w_transfer_prev;
  logic w_transfer_next;
  logic w_is_mem;
  logic w_operand_bad;
  logic w_f3_illegal;
  logic w_misaligned;
  logic w_in_exc;
  logic [1:0] w_accept_state;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [DATA_WIDTH-1:0] w_load_data;

  assign w_transfer_prev = prev_done && !stall_prev;
  assign w_transfer_next = done_next && !next_stall;

  // Classification of the instruction currently offered upstream.
  assign w_is_mem      = load_in || store_in;
  assign w_operand_bad = !result_data_valid_in || !funct_3_valid_in ||
                         (store_in && !memory_store_data_valid_in);
  // Loads allow 000/001/010/100/101; stores only 000/001/010.
  assign w_f3_illegal  = store_in ? (funct_3_in[2] || (funct_3_in[1:0] == 2'b11))
                                  : ((funct_3_in == 3'b011) || (funct_3_in[2:1] == 2'b11));
  assign w_misaligned  = ((funct_3_in[1:0] == 2'b01) && result_data_in[0]) ||
                         ((funct_3_in == 3'b010) && (result_data_in[1:0] != 2'b00));
  assign w_in_exc      = w_is_mem && (w_operand_bad || w_f3_illegal || w_misaligned);
  assign w_accept_state = (w_is_mem && !w_in_exc) ? S_REQ : S_HOLD;

  // Bring the addressed byte/half down to bit 0 before extension.
  assign w_shifted = mem_rdata >> {ea_q[1:0], 3'b000};

  always_comb begin
    w_load_data = w_shifted;
    case (f3_q)
      3'b000:  w_load_data = {{24{w_shifted[7]}},  w_shifted[7:0]};
      3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
      3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (w_transfer_prev) state_d = w_accept_state;
      S_REQ:  if (mem_req_ready)   state_d = S_RESP;
      S_RESP: if (mem_resp_valid)  state_d = S_HOLD;
      S_HOLD: begin
        if (w_transfer_next) begin
          state_d = w_transfer_prev ? w_accept_state : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic. stall_prev is forced high while reset is asserted.
  always_comb begin
    done_next     = (state_q == S_HOLD);
    mem_req_valid = (state_q == S_REQ);
    stall_prev    = !rst_n ||
                    !((state_q == S_IDLE) || ((state_q == S_HOLD) && !next_stall));
  end

  // Instruction and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q           <= '0;
      store_q        <= 1'b0;
      f3_q           <= 3'b000;
      ea_q           <= '0;
      sdata_q        <= '0;
      rd_q           <= '0;
      rd_valid_q     <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      exc_q          <= 1'b0;
    end else if (w_transfer_prev) begin
      pc_q           <= program_count_in;
      store_q        <= store_in;
      f3_q           <= funct_3_in;
      ea_q           <= result_data_in;
      sdata_q        <= memory_store_data_in;
      rd_q           <= write_register_in;
      rd_valid_q     <= write_register_valid_in;
      // Memory ops fill in the result when the response arrives.
      result_q       <= w_is_mem ? '0 : result_data_in;
      result_valid_q <= w_is_mem ? 1'b0 : result_data_valid_in;
      exc_q          <= w_in_exc;
    end else if ((state_q == S_RESP) && mem_resp_valid) begin
      result_q       <= store_q ? '0 : w_load_data;
      result_valid_q <= !store_q;
    end
  end

  assign program_count_out        = pc_q;
  assign write_register_out       = rd_q;
  assign write_register_valid_out = rd_valid_q;
  assign result_data_out          = result_q;
  assign result_data_valid_out    = result_valid_q;
  assign memory_exception_out     = exc_q;

  // Request fields derive only from captured registers, so they stay stable
  // for the whole time the request waits on mem_req_ready.
  assign mem_addr  = {ea_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_write = store_q;

  always_comb begin
    mem_wdata = sdata_q;
    mem_wstrb = 4'b1111;
    case (f3_q[1:0])
      2'b00: begin
        mem_wdata = {4{sdata_q[7:0]}};
        mem_wstrb = 4'b0001 << ea_q[1:0];
      end
      2'b01: begin
        mem_wdata = {2{sdata_q[15:0]}};
        mem_wstrb = 4'b0011 << ea_q[1:0];
      end
      default: begin
        mem_wdata = sdata_q;
        mem_wstrb = 4'b1111;
      end
    endcase
  end

endmodule
`default_nettype wire
